// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller and the IF/ID register.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        BR_FLUSH = 2'd1,
        IF_WAIT  = 2'd2
    } state_t;

    localparam logic [4:0]  REG_X0 = 5'd0;

    // addi x0, x0, 0 -- loaded into IF/ID whenever it is flushed
    localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/sat_counter.sv
// Statistics counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/hazard_flush_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and imem wait handling.
//   state    | meaning
//   RUN      | normal issue; hazards are detected here
//   BR_FLUSH | extra flush cycles after a taken branch
//   IF_WAIT  | instruction memory stalled; downstream drains
module hazard_flush_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int TIMEOUT      = 16,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs2,
    input  logic             id_ex_memread,
    input  logic [4:0]       id_ex_rd,
    input  logic             br_taken,
    input  logic             imem_ready,
    output logic             pc_write,
    output logic             pc_sel_branch,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_sel,
    output logic             fetch_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_W  = 8'(TIMEOUT);

    state_t     state, state_nxt;
    logic [1:0] flush_left, flush_left_nxt;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic       load_use, take_branch, timeout_hit, stall_inc, flush_inc;

    assign load_use = id_ex_memread && (id_ex_rd != REG_X0) &&
                      ((id_ex_rd == id_rs1) || (id_uses_rs2 && (id_ex_rd == id_rs2)));

    // Branches resolved while flushing come from the squashed path and are dropped
    assign take_branch = br_taken && (state != BR_FLUSH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= RUN;
            flush_left    <= '0;
            wait_cnt      <= '0;
            fetch_timeout <= 1'b0;
        end else begin
            state      <= state_nxt;
            flush_left <= flush_left_nxt;
            wait_cnt   <= wait_cnt_nxt;
            if (timeout_hit) fetch_timeout <= 1'b1;
        end
    end

    always_comb begin
        pc_write       = 1'b1;
        if_id_write    = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_sel      = 1'b1;
        pc_sel_branch  = 1'b0;
        state_nxt      = state;
        flush_left_nxt = flush_left;
        wait_cnt_nxt   = wait_cnt;
        timeout_hit    = 1'b0;
        stall_inc      = 1'b0;
        flush_inc      = 1'b0;

        if (!reset) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_id_flush = 1'b1;
            id_ex_sel   = 1'b0;
        end else if (take_branch) begin
            pc_sel_branch = 1'b1;
            if_id_flush   = 1'b1;
            id_ex_sel     = 1'b0;
            flush_inc     = 1'b1;
            wait_cnt_nxt  = '0;
            if (FLUSH_CYCLES > 1) begin
                state_nxt      = BR_FLUSH;
                flush_left_nxt = FLUSH_INIT;
            end else begin
                state_nxt = RUN;
            end
        end else begin
            case (state)
                RUN: begin
                    if (load_use) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_sel   = 1'b0;
                        stall_inc   = 1'b1;
                    end else if (!imem_ready) begin
                        pc_write     = 1'b0;
                        if_id_flush  = 1'b1;
                        wait_cnt_nxt = 8'd1;
                        state_nxt    = IF_WAIT;
                    end
                end
                BR_FLUSH: begin
                    pc_write       = imem_ready;
                    if_id_flush    = 1'b1;
                    id_ex_sel      = 1'b0;
                    flush_left_nxt = flush_left - 2'd1;
                    if (flush_left <= 2'd1) state_nxt = RUN;
                end
                IF_WAIT: begin
                    if (imem_ready) begin
                        wait_cnt_nxt = '0;
                        state_nxt    = RUN;
                    end else begin
                        pc_write    = 1'b0;
                        if_id_flush = 1'b1;
                        if (wait_cnt != TIMEOUT_W) wait_cnt_nxt = wait_cnt + 8'd1;
                        if (wait_cnt_nxt == TIMEOUT_W) timeout_hit = 1'b1;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Directed bench: one 3-cycle-flush / 4-bit-counter instance and one default instance on shared inputs.
module tb_hazard_flush_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, id_ex_rd;
    logic       id_uses_rs2, id_ex_memread, br_taken, imem_ready;

    logic        a_pcw, a_pcb, a_ifw, a_iff, a_sel, a_to;
    logic [3:0]  a_stall, a_flush;
    logic        b_pcw, b_pcb, b_ifw, b_iff, b_sel, b_to;
    logic [31:0] b_stall, b_flush;

    int total = 0;
    int bad   = 0;

    // {pc_write, if_id_write, if_id_flush, id_ex_sel, pc_sel_branch}
    localparam logic [4:0] C_RST  = 5'b00100;
    localparam logic [4:0] C_DEF  = 5'b11010;
    localparam logic [4:0] C_LU   = 5'b00000;
    localparam logic [4:0] C_BR   = 5'b11101;
    localparam logic [4:0] C_FL   = 5'b11100;
    localparam logic [4:0] C_FLNR = 5'b01100;
    localparam logic [4:0] C_WAIT = 5'b01110;

    wire [4:0] a_ctrl = {a_pcw, a_ifw, a_iff, a_sel, a_pcb};
    wire [4:0] b_ctrl = {b_pcw, b_ifw, b_iff, b_sel, b_pcb};

    always #5 clk = ~clk;

    hazard_flush_ctrl #(.FLUSH_CYCLES(3), .TIMEOUT(16), .CNT_W(4)) dut_a (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs2(id_uses_rs2), .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
        .br_taken(br_taken), .imem_ready(imem_ready),
        .pc_write(a_pcw), .pc_sel_branch(a_pcb), .if_id_write(a_ifw), .if_id_flush(a_iff),
        .id_ex_sel(a_sel), .fetch_timeout(a_to), .stall_cnt(a_stall), .flush_cnt(a_flush)
    );

    hazard_flush_ctrl dut_b (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs2(id_uses_rs2), .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
        .br_taken(br_taken), .imem_ready(imem_ready),
        .pc_write(b_pcw), .pc_sel_branch(b_pcb), .if_id_write(b_ifw), .if_id_flush(b_iff),
        .id_ex_sel(b_sel), .fetch_timeout(b_to), .stall_cnt(b_stall), .flush_cnt(b_flush)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_ex_rd = 5'd0;
        id_uses_rs2 = 1'b0; id_ex_memread = 1'b0; br_taken = 1'b0; imem_ready = 1'b1;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic lu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic uses2);
        id_ex_memread = 1'b1; id_ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs2 = uses2;
    endtask

    initial begin
        idle();
        reset = 1'b0;
        #12;
        chk("rst_ctrl_a", a_ctrl, C_RST);
        chk("rst_ctrl_b", b_ctrl, C_RST);
        chk("rst_stall", a_stall, 0);
        chk("rst_flush", a_flush, 0);
        chk("rst_timeout", a_to, 0);
        reset = 1'b1;
        cyc();

        #1 chk("idle_ctrl", a_ctrl, C_DEF);

        // load-use on rs1: one-cycle stall
        lu(5'd5, 5'd5, 5'd0, 1'b0);
        #1 chk("lu_ctrl_a", a_ctrl, C_LU);
        chk("lu_ctrl_b", b_ctrl, C_LU);
        cyc();
        idle();
        #1 chk("lu_after_ctrl", a_ctrl, C_DEF);
        chk("lu_stall_a", a_stall, 1);
        chk("lu_stall_b", b_stall, 1);

        // rd = x0 never stalls
        lu(5'd0, 5'd0, 5'd0, 1'b0);
        #1 chk("x0_ctrl", a_ctrl, C_DEF);
        cyc();
        chk("x0_stall", a_stall, 1);

        // rs2 match only counts when rs2 is used
        lu(5'd7, 5'd3, 5'd7, 1'b0);
        #1 chk("rs2_unused_ctrl", a_ctrl, C_DEF);
        cyc();
        chk("rs2_unused_stall", a_stall, 1);
        id_uses_rs2 = 1'b1;
        #1 chk("rs2_used_ctrl", a_ctrl, C_LU);
        cyc();
        chk("rs2_used_stall", a_stall, 2);
        idle();

        // branch with load-use also true: branch wins
        lu(5'd5, 5'd5, 5'd0, 1'b0);
        br_taken = 1'b1;
        #1 chk("br_ctrl_a", a_ctrl, C_BR);
        chk("br_ctrl_b", b_ctrl, C_BR);
        cyc();
        idle();
        #1 chk("br_fl1_a", a_ctrl, C_FL);
        chk("br_fl1_b", b_ctrl, C_DEF);
        chk("br_stall_a", a_stall, 2);
        chk("br_flush_a", a_flush, 1);
        chk("br_flush_b", b_flush, 1);
        cyc();
        // branch during flush is ignored; imem stall gates the PC
        br_taken = 1'b1; imem_ready = 1'b0;
        #1 chk("br_fl2_a", a_ctrl, C_FLNR);
        chk("br_new_b", b_ctrl, C_BR);
        cyc();
        idle();
        #1 chk("br_done_a", a_ctrl, C_DEF);
        chk("br_done_b", b_ctrl, C_DEF);
        chk("br_ign_flush_a", a_flush, 1);
        chk("br_flush2_b", b_flush, 2);

        // short imem wait
        imem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 chk("wait4_ctrl", a_ctrl, C_WAIT);
            cyc();
        end
        imem_ready = 1'b1;
        #1 chk("wait4_resume", a_ctrl, C_DEF);
        chk("wait4_timeout", a_to, 0);
        cyc();

        // long imem wait reaches the timeout
        imem_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1 chk("wait16_ctrl", a_ctrl, C_WAIT);
            cyc();
            if (i == 14) chk("wait15_timeout", a_to, 0);
        end
        chk("wait16_timeout_a", a_to, 1);
        chk("wait16_timeout_b", b_to, 1);
        imem_ready = 1'b1;
        #1 chk("wait16_resume", a_ctrl, C_DEF);
        cyc();
        chk("timeout_sticky", a_to, 1);

        // branch overrides IF_WAIT, then reset in the second flush cycle
        imem_ready = 1'b0;
        cyc();
        br_taken = 1'b1;
        #1 chk("wait_br_ctrl", a_ctrl, C_BR);
        cyc();
        idle();
        chk("wait_br_flush", a_flush, 2);
        #1 chk("wait_br_fl1", a_ctrl, C_FL);
        cyc();
        #1 chk("wait_br_fl2", a_ctrl, C_FL);
        reset = 1'b0;
        #1 chk("mid_rst_ctrl", a_ctrl, C_RST);
        chk("mid_rst_flush", a_flush, 0);
        chk("mid_rst_stall", a_stall, 0);
        chk("mid_rst_timeout", a_to, 0);
        #1 reset = 1'b1;
        #1 chk("mid_rst_run", a_ctrl, C_DEF);
        cyc();

        // 20 load-use events: 4-bit counter saturates at 15
        for (int i = 0; i < 20; i++) begin
            lu(5'd9, 5'd9, 5'd0, 1'b0);
            cyc();
            idle();
            cyc();
            if (i == 14) chk("sat_15", a_stall, 15);
        end
        chk("sat_hold_a", a_stall, 15);
        chk("sat_wide_b", b_stall, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
